// File: rtl/dmem_resp_if.sv
// dmem_resp_if: load/store bus between the MEM-stage memory controller
// (master) and the data-memory responder (slave).
//   as_      address strobe, active low; a request is valid while 0
//   rw       1 = read, 0 = write
//   addr     30-bit word address (byte address bits [31:2])
//   wr_data  store data
//   rd_data  load data returned by the responder
//   rdy_     ready, active low, one-cycle pulse per completed access
//   err      error flag, meaningful only while rdy_ = 0
interface dmem_resp_if;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        err;

  modport master (output as_, rw, addr, wr_data, input rd_data, rdy_, err);
  modport slave  (input as_, rw, addr, wr_data, output rd_data, rdy_, err);
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder, the slave end of the CPU load/store bus.
// A request is captured while as_ = 0 in IDLE, held for WAIT_CYCLES wait
// states, then performed on an internal word-addressed RAM. Completion is
// signalled by a one-cycle active-low rdy_ pulse; reads return the full
// 32-bit word on rd_data (registered, held until the next completed read).
//
// Ports:
//   clk    system clock, everything on the rising edge
//   rst_n  synchronous active-low reset (RAM contents are not reset)
//   bus    dmem_resp_if.slave: as_, rw, addr, wr_data in; rd_data, rdy_, err out
//
// Parameters:
//   DEPTH        RAM depth in 32-bit words (power of two)
//   ADDR_W       log2(DEPTH)
//   WAIT_CYCLES  wait states between capture and access (0..15)
//
// Optional feature: define DMEM_RANGE_CHECK_EN to flag accesses with any of
// addr[29:ADDR_W] set as out of range (no write, rd_data <= 0, err = 1 with
// rdy_). Without it err stays 0 and addresses alias modulo DEPTH.
module dmem_resp #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic        clk,
  input logic        rst_n,
  dmem_resp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        rw_l_r;
  logic [29:0] addr_l_r;
  logic [31:0] wr_data_l_r;
  logic [31:0] rd_data_r;
  logic        rdy_n_r;       // active-low ready
  logic        err_r;
  logic [31:0] mem_r [DEPTH];

  logic [ADDR_W-1:0] idx_s;
  logic              access_s;
  logic              oor_s;
  logic              mem_we_s;

`ifdef DMEM_RANGE_CHECK_EN
  // Any set bit above the RAM index makes the latched address out of range.
  always_comb begin
    oor_s = |addr_l_r[29:ADDR_W];
  end
`else
  // Upper address bits alias; keep them visibly consumed so they are not
  // mistaken for dead logic.
  logic unused_addr_hi_s;

  // No range check in this build.
  always_comb begin
    oor_s            = 1'b0;
    unused_addr_hi_s = ^addr_l_r[29:ADDR_W];
  end
`endif

  // Access-edge decode and RAM write enable. Gating with rst_n makes a reset
  // coinciding with the access edge abort the pending write.
  always_comb begin
    idx_s    = addr_l_r[ADDR_W-1:0];
    access_s = (state_r == BUSY) && (cnt_r == 4'd0);
    mem_we_s = rst_n && access_s && !rw_l_r && !oor_s;
  end

  // RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= wr_data_l_r;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rw_l_r      <= 1'b0;
      addr_l_r    <= 30'd0;
      wr_data_l_r <= 32'd0;
      rd_data_r   <= 32'd0;
      rdy_n_r     <= 1'b1;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rdy_n_r <= 1'b1;
          err_r   <= 1'b0;
          if (!bus.as_) begin
            // Latch the whole request; bus inputs are ignored from here on.
            rw_l_r      <= bus.rw;
            addr_l_r    <= bus.addr;
            wr_data_l_r <= bus.wr_data;
            cnt_r       <= 4'(WAIT_CYCLES);
            state_r     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            // Access edge: the write itself happens in the RAM write port.
            if (oor_s) begin
              rd_data_r <= 32'd0;
            end else if (rw_l_r) begin
              rd_data_r <= mem_r[idx_s];
            end
            err_r   <= oor_s;
            rdy_n_r <= 1'b0;
            state_r <= RESP;
          end
        end
        RESP: begin
          // as_ is not looked at here; any held strobe is seen next in IDLE.
          rdy_n_r <= 1'b1;
          err_r   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          rdy_n_r <= 1'b1;
          err_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_data = rd_data_r;
  assign bus.rdy_    = rdy_n_r;
  assign bus.err     = err_r;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp. Three instances (WAIT_CYCLES 0, 1, 3)
// share clock and reset. Expected responses come from a bench-side memory
// model, are queued when a request is issued and popped when rdy_ pulses.
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dmem_resp_if bi0 ();
  dmem_resp_if bi1 ();
  dmem_resp_if bi3 ();

  dmem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave));
  dmem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(bi1.slave));
  dmem_resp #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst_n(rst_n), .bus(bi3.slave));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  logic [31:0] last_rd[4];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference behaviour of one access on instance w; updates the model.
  function automatic exp_t predict(input int w, input logic rw_v, input logic [29:0] a, input logic [31:0] d);
    exp_t e;
    logic oor;
    int   key;
    key = w * 4096 + int'(a[9:0]);
`ifdef DMEM_RANGE_CHECK_EN
    oor = (a[29:10] != 20'd0);
`else
    oor = 1'b0;
`endif
    e.lat = w + 1;
    e.err = oor;
    if (oor) begin
      last_rd[w] = 32'd0;
    end else if (rw_v) begin
      last_rd[w] = model.exists(key) ? model[key] : 32'hxxxx_xxxx;
    end else begin
      model[key] = d;
    end
    e.data = last_rd[w];
    return e;
  endfunction

  task automatic drive(input int w, input logic as_v, input logic rw_v, input logic [29:0] a, input logic [31:0] d);
    case (w)
      0:       begin bi0.as_ = as_v; bi0.rw = rw_v; bi0.addr = a; bi0.wr_data = d; end
      3:       begin bi3.as_ = as_v; bi3.rw = rw_v; bi3.addr = a; bi3.wr_data = d; end
      default: begin bi1.as_ = as_v; bi1.rw = rw_v; bi1.addr = a; bi1.wr_data = d; end
    endcase
  endtask

  task automatic sample(input int w, output logic r, output logic [31:0] q, output logic e);
    case (w)
      0:       begin r = bi0.rdy_; q = bi0.rd_data; e = bi0.err; end
      3:       begin r = bi3.rdy_; q = bi3.rd_data; e = bi3.err; end
      default: begin r = bi1.rdy_; q = bi1.rd_data; e = bi1.err; end
    endcase
  endtask

  // One request: strobe for the capture edge, then present (a2,d2) on the
  // bus while the responder is busy. Reports edges from capture to the first
  // rdy_ low sample (-1 on timeout), the data/err seen then, and rdy_ one
  // cycle later.
  task automatic issue(input int w, input logic rw_v, input logic [29:0] a, input logic [31:0] d,
                       input logic [29:0] a2, input logic [31:0] d2,
                       output int lat, output logic [31:0] rdv, output logic errv, output logic after_v);
    logic r, e, done;
    logic [31:0] q;
    lat = -1; rdv = 32'd0; errv = 1'b0; after_v = 1'b0; done = 1'b0;
    drive(w, 1'b0, rw_v, a, d);
    @(posedge clk); @(negedge clk);
    drive(w, 1'b1, rw_v, a2, d2);
    for (int k = 1; k <= 30; k++) begin
      if (!done) begin
        @(posedge clk); @(negedge clk);
        sample(w, r, q, e);
        if (r === 1'b0) begin
          lat = k; rdv = q; errv = e; done = 1'b1;
          @(posedge clk); @(negedge clk);
          sample(w, after_v, q, e);
        end
      end
    end
  endtask

  // Issue one access and check latency, pulse width, data and err.
  task automatic txn(input string tag, input int w, input logic rw_v, input logic [29:0] a, input logic [31:0] d,
                     input logic [29:0] a2, input logic [31:0] d2);
    int lat;
    logic [31:0] rdv;
    logic errv, after_v;
    exp_t e;
    sb.push_back(predict(w, rw_v, a, d));
    issue(w, rw_v, a, d, a2, d2, lat, rdv, errv, after_v);
    e = sb.pop_front();
    n_checks += 4;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat); else n_pass++;
    if (after_v !== 1'b1) $display("FAIL %s pulse_width: rdy_ after pulse got %b want 1", tag, after_v); else n_pass++;
    if (rdv !== e.data) $display("FAIL %s rd_data: got %h want %h", tag, rdv, e.data); else n_pass++;
    if (errv !== e.err) $display("FAIL %s err: got %b want %b", tag, errv, e.err); else n_pass++;
  endtask

  task automatic test_reset();
    logic r, e;
    logic [31:0] q;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b0, 30'd0, 32'd0);
    drive(3, 1'b1, 1'b0, 30'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 30'h9, 32'h0BAD_F00D);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      if (w != 2) begin
        last_rd[w] = 32'd0;
        sample(w, r, q, e);
        n_checks += 3;
        if (r !== 1'b1) $display("FAIL reset_rdy w%0d: got %b want 1", w, r); else n_pass++;
        if (q !== 32'd0) $display("FAIL reset_rd_data w%0d: got %h want 0", w, q); else n_pass++;
        if (e !== 1'b0) $display("FAIL reset_err w%0d: got %b want 0", w, e); else n_pass++;
      end
    end
    rst_n = 1'b1;
    // as_ is still low: the first edge after release must capture the write.
    txn("reset_release", 1, 1'b0, 30'h9, 32'h0BAD_F00D, 30'h9, 32'h0BAD_F00D);
  endtask

  task automatic test_write_read();
    txn("wr_5", 1, 1'b0, 30'h5, 32'hDEAD_BEEF, 30'h5, 32'hDEAD_BEEF);
    txn("rd_5", 1, 1'b1, 30'h5, 32'd0, 30'h5, 32'd0);
    txn("rd_9", 1, 1'b1, 30'h9, 32'd0, 30'h9, 32'd0);
    txn("wr_3ff", 1, 1'b0, 30'h3FF, 32'h5A5A_A5A5, 30'h3FF, 32'h5A5A_A5A5);
    txn("rd_3ff", 1, 1'b1, 30'h3FF, 32'd0, 30'h3FF, 32'd0);
  endtask

  task automatic test_wait_sweep();
    txn("w0_wr", 0, 1'b0, 30'h10, 32'h0101_0101, 30'h10, 32'h0101_0101);
    txn("w0_rd", 0, 1'b1, 30'h10, 32'd0, 30'h10, 32'd0);
    txn("w3_wr", 3, 1'b0, 30'h22, 32'h0303_0303, 30'h22, 32'h0303_0303);
    txn("w3_rd", 3, 1'b1, 30'h22, 32'd0, 30'h22, 32'd0);
  endtask

  task automatic test_hold_off();
    txn("ho_pre6", 1, 1'b0, 30'h6, 32'h6666_6666, 30'h6, 32'h6666_6666);
    txn("ho_wr5", 1, 1'b0, 30'h5, 32'hCAFE_F00D, 30'h6, 32'h0BAD_0BAD);
    txn("ho_rd5", 1, 1'b1, 30'h5, 32'd0, 30'h5, 32'd0);
    txn("ho_rd6", 1, 1'b1, 30'h6, 32'd0, 30'h6, 32'd0);
  endtask

  task automatic test_back_to_back();
    int p[2];
    int np;
    logic r, e;
    logic [31:0] q;
    exp_t ex;
    np = 0; p[0] = -1; p[1] = -1;
    sb.push_back(predict(1, 1'b1, 30'h5, 32'd0));
    sb.push_back(predict(1, 1'b1, 30'h5, 32'd0));
    drive(1, 1'b0, 1'b1, 30'h5, 32'd0);
    for (int k = 0; k <= 40; k++) begin
      if (np < 2) begin
        @(posedge clk); @(negedge clk);
        sample(1, r, q, e);
        if (r === 1'b0) begin
          p[np] = k;
          np++;
          ex = sb.pop_front();
          n_checks++;
          if (q !== ex.data) $display("FAIL b2b_data%0d: got %h want %h", np, q, ex.data); else n_pass++;
          if (np == 2) drive(1, 1'b1, 1'b1, 30'h5, 32'd0);
        end
      end
    end
    if (np < 2) drive(1, 1'b1, 1'b1, 30'h5, 32'd0);
    n_checks += 2;
    if (p[0] !== 2) $display("FAIL b2b_first: got edge %0d want 2", p[0]); else n_pass++;
    if (p[1] - p[0] !== 4) $display("FAIL b2b_spacing: got %0d want 4", p[1] - p[0]); else n_pass++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_range();
    txn("rg_wr0", 1, 1'b0, 30'h0, 32'hAAAA_0000, 30'h0, 32'hAAAA_0000);
    txn("rg_wr400", 1, 1'b0, 30'h400, 32'h1234_5678, 30'h400, 32'h1234_5678);
    txn("rg_rd0", 1, 1'b1, 30'h0, 32'd0, 30'h0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait_sweep();
    test_hold_off();
    test_back_to_back();
    test_range();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the slave end of the CPU load/store interface.
- Samples the active-low address strobe, word address, rw and write data issued by the MEM-stage memory controller.
- Performs the access on an internal word-addressed RAM after a programmable number of wait states.
- Returns read data with a one-cycle active-low ready pulse.

Parameters:
- DEPTH, 1024, number of 32-bit words in the RAM; must be a power of two.
- ADDR_W, 10, index bits; must equal log2(DEPTH).
- WAIT_CYCLES, 1, extra wait states between request capture and access (0..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- as_  input  1  address strobe, active low; request valid when 0.
- rw  input  1  1 = READ, 0 = WRITE.
- addr  input  30  word address (byte address bits [31:2]).
- wr_data  input  32  store data.
- rd_data  output  32  load data, registered.
- rdy_  output  1  ready, active low; one-cycle pulse per completed access.
- err  output  1  error flag, valid only while rdy_=0.

Behaviour:
- Reset, sampled at a clock edge with rst_n=0:
  - state=IDLE, counter=0, rd_data=0, rdy_=1, err=0.
  - RAM contents are not reset.
  - Reset mid-access aborts the access. A pending write is not performed unless its ACCESS edge has already occurred.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On an edge with as_=0: latch addr, rw and wr_data; load counter with WAIT_CYCLES; go to BUSY.
  - With as_=1: remain in IDLE.
- BUSY:
  - If counter != 0: decrement and stay in BUSY.
  - If counter == 0 (the access edge):
    - Read: rd_data <= mem[addr_l[ADDR_W-1:0]].
    - Write: mem[addr_l[ADDR_W-1:0]] <= wr_data_l; rd_data unchanged.
    - rdy_ <= 0; go to RESP.
- RESP:
  - Next edge: rdy_ <= 1, err <= 0, go to IDLE unconditionally.
  - as_ is ignored in RESP.
- Latency: request captured at edge E0 → rdy_ low from edge E(WAIT_CYCLES+1) for exactly one cycle. Back-to-back minimum request spacing is WAIT_CYCLES+3 edges.
- Initiator rule: the initiator must deassert as_ in the cycle after it observes rdy_=0. If as_ is still 0 when the FSM is in IDLE, that is a new request.
- Inputs are ignored while in BUSY and RESP; the latched copies are used. Changes to addr, rw or wr_data after capture have no effect.
- rd_data holds its value until the next completed read, including across writes and idle cycles.
- Write then read of the same address returns the new data: the write commits at its access edge, before any later request is captured.
- Address bits [29:ADDR_W] are ignored (aliasing) unless the optional feature is enabled.
- Byte/halfword extraction and sign extension are not performed here. The full word is returned; the requester handles extraction.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - At the access edge, if any latched addr bit [29:ADDR_W] is 1, the access is out of range.
  - An out-of-range access performs no write, drives rd_data to 0, and asserts err=1 in the same cycle as rdy_=0.
  - err returns to 0 with rdy_.
  - In-range accesses give err=0.
- Undefined: err is tied to 0, addresses alias modulo DEPTH, and no range logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with as_=0 → rdy_=1, rd_data=0, err=0, no request captured. Release; the first as_=0 edge then starts a request.
- Write/read, WAIT_CYCLES=1: write addr=0x5, wr_data=0xDEADBEEF → rdy_ low exactly at edge E2 for 1 cycle. Then read addr=0x5 → rd_data=0xDEADBEEF at rdy_ low.
- Wait-state sweep, WAIT_CYCLES=0 and 3: read request at E0 → rdy_ low at E1 and E4 respectively. rdy_ stays high in all other cycles.
- Input hold-off: change addr from 0x5 to 0x6 and wr_data during BUSY → access uses 0x5 and the original data. Reading 0x6 afterwards returns its previous content.
- as_ held low through RESP → second request captured at the first IDLE edge. Two rdy_ pulses separated by WAIT_CYCLES+3 edges.
- Range, DMEM_RANGE_CHECK_EN defined, DEPTH=1024:
  - Write addr=0x400 with data 0x12345678 → err=1 with rdy_, and mem[0] is unchanged.
  - Same write with the macro undefined → mem[0]=0x12345678 and err=0.
